// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor, LSB digit first.
// Each accepted operation takes N = WIDTH/DIGIT_W BUSY cycles, then the result
// is held in DONE until the consumer takes it.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   a_i, b_i  minuend / subtrahend (unsigned, WIDTH bits)
//   valid_i   operands valid (taken only while ready_o is high)
//   ready_o   high in IDLE only
//   diff_o    (a - b) mod 2^WIDTH, zero unless valid_o
//   bo_o      borrow out (a < b), zero unless valid_o
//   valid_o   high in DONE only
//   ready_i   consumer accepts the result
//   energy_o  IEEE-754 double bit pattern of per-cycle energy in joules
module serial_subtractor #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bo_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [63:0]      energy_o
);

  localparam int unsigned N     = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam real E_STEP_J = 1.0e-12 * (0.00045606 * DIGIT_W * DIGIT_W
                                      + 0.04853065 * DIGIT_W
                                      + 0.04391967);
  localparam logic [63:0] E_STEP_BITS = $realtobits(E_STEP_J);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
  logic               d_borrow;

  // Select the digit addressed by the step counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // One extra bit: its top bit is set exactly when a_dig < b_dig + borrow.
  always_comb begin
    {d_borrow, d_dig} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT_W{1'b0}}, borrow_q};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            res_d[i*DIGIT_W +: DIGIT_W] = d_dig;
          end
        end
        borrow_d = d_borrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Results are masked outside DONE so partial digits never leak out.
  always_comb begin
    ready_o  = (state_q == IDLE);
    valid_o  = (state_q == DONE);
    diff_o   = valid_o ? res_q : '0;
    bo_o     = valid_o & borrow_q;
    energy_o = (state_q == BUSY) ? E_STEP_BITS : '0;
  end

endmodule
